// File: rtl/wn_pdcchrx_toneavg_pkg.sv
// Shared types and constants for the PDCCH RX tone-averaging block.
package wn_pdcchrx_toneavg_pkg;
  localparam int CFG_W        = 5;
  localparam int CFG_L2N_LSB  = 0;
  localparam int CFG_L2N_W    = 3;
  localparam int CFG_MODE_LSB = 3;
  localparam int CFG_MODE_W   = 2;

  typedef enum logic [1:0] {
    MODE_BYP  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_REP  = 2'b10,
    MODE_BYP3 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_ACC,
    ST_OUT
  } state_e;
endpackage

// File: rtl/wn_pdcchrx_toneavg_acc.sv
// One signed I or Q component: accumulate, optional round, shift by log2N, saturate.
// Rounding (half up) is enabled by defining WN_TONEAVG_ROUND_EN; otherwise floor.
module wn_pdcchrx_toneavg_acc
  import wn_pdcchrx_toneavg_pkg::*;
#(
  parameter int DW        = 16,
  parameter int MAX_LOG2N = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 done,
  input  logic [CFG_L2N_W-1:0] log2n,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] avg
);
  localparam int AW = DW + MAX_LOG2N;
  localparam logic signed [AW-1:0] SMAX = {{(MAX_LOG2N+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(MAX_LOG2N+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] acc, sum, rnd, shf;
  logic        [AW-1:0] one;

  // avg reflects the sum including the current beat so it can be latched on the group's last beat
  always_comb begin
    one = AW'(1);
    sum = acc + AW'(din);
    rnd = '0;
`ifdef WN_TONEAVG_ROUND_EN
    if (log2n != '0) rnd = signed'(one << (log2n - 3'd1));
`endif
    shf = (sum + rnd) >>> log2n;
    if (shf > SMAX)      avg = SMAX[DW-1:0];
    else if (shf < SMIN) avg = SMIN[DW-1:0];
    else                 avg = shf[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) acc <= '0;
    else if (en)      acc <= done ? '0 : sum;
  end
endmodule

// File: rtl/wn_pdcchrx_freq_toneavg_nrx.sv
// Per-antenna tone averager over groups of 2^log2N tones: bypass, decimate or replicate.
// Optional round-half-up selected by WN_TONEAVG_ROUND_EN (see accumulator).
module wn_pdcchrx_freq_toneavg_nrx
  import wn_pdcchrx_toneavg_pkg::*;
#(
  parameter int nRx       = 2,
  parameter int DW        = 16,
  parameter int MAX_LOG2N = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [CFG_W-1:0]      config_in_tdata,
  input  logic                  config_in_tvalid,
  output logic                  config_in_tready,
  input  logic [nRx*2*DW-1:0]   data_in_tdata,
  input  logic                  data_in_tvalid,
  output logic                  data_in_tready,
  input  logic                  data_in_tlast,
  output logic [nRx*2*DW-1:0]   data_out_tdata,
  output logic                  data_out_tvalid,
  input  logic                  data_out_tready,
  output logic                  data_out_tlast
);
  localparam int CW = MAX_LOG2N + 1;

  state_e               state;
  mode_e                cfg_mode;
  logic [CFG_L2N_W-1:0] cfg_log2n, l2n_in, l2n_clamp;
  logic [CW-1:0]        cnt, rem, rem_n, nm1;
  logic                 last_seen;
  logic                 acc_en, acc_done, acc_clr, in_hs;
  logic [nRx*2*DW-1:0]  avg_w;

  always_comb begin
    l2n_in    = config_in_tdata[CFG_L2N_LSB +: CFG_L2N_W];
    l2n_clamp = (int'(l2n_in) > MAX_LOG2N) ? CFG_L2N_W'(MAX_LOG2N) : l2n_in;
    nm1       = (CW'(1) << cfg_log2n) - CW'(1);
    rem_n     = (cfg_mode == MODE_REP) ? cnt + CW'(1) : CW'(1);
  end

  assign config_in_tready = rstn && (state == ST_IDLE);
  assign data_in_tready   = rstn && ((state == ST_ACC) ||
                            ((state == ST_PASS) && !last_seen && (data_out_tready || !data_out_tvalid)));
  assign in_hs    = data_in_tvalid && data_in_tready;
  assign acc_en   = (state == ST_ACC) && data_in_tvalid;
  assign acc_done = acc_en && ((cnt == nm1) || data_in_tlast);
  assign acc_clr  = (state == ST_IDLE);

  for (genvar g = 0; g < 2*nRx; g++) begin : g_acc
    wn_pdcchrx_toneavg_acc #(.DW(DW), .MAX_LOG2N(MAX_LOG2N)) u_acc (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (acc_clr),
      .en    (acc_en),
      .done  (acc_done),
      .log2n (cfg_log2n),
      .din   (data_in_tdata[g*DW +: DW]),
      .avg   (avg_w[g*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      cfg_mode        <= MODE_BYP;
      cfg_log2n       <= '0;
      cnt             <= '0;
      rem             <= '0;
      last_seen       <= 1'b0;
      data_out_tvalid <= 1'b0;
      data_out_tlast  <= 1'b0;
      data_out_tdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (config_in_tvalid) begin
          cfg_mode  <= mode_e'(config_in_tdata[CFG_MODE_LSB +: CFG_MODE_W]);
          cfg_log2n <= l2n_clamp;
          cnt       <= '0;
          last_seen <= 1'b0;
          case (mode_e'(config_in_tdata[CFG_MODE_LSB +: CFG_MODE_W]))
            MODE_DEC, MODE_REP: state <= ST_ACC;
            default:            state <= ST_PASS;
          endcase
        end
        ST_PASS: begin
          // a tlast beat blocks further input, so in_hs and the final output handshake never coincide
          if (in_hs) begin
            data_out_tdata  <= data_in_tdata;
            data_out_tvalid <= 1'b1;
            data_out_tlast  <= data_in_tlast;
            if (data_in_tlast) last_seen <= 1'b1;
          end else if (data_out_tready && data_out_tvalid) begin
            data_out_tvalid <= 1'b0;
            data_out_tlast  <= 1'b0;
            if (data_out_tlast) state <= ST_IDLE;
          end
        end
        ST_ACC: if (acc_en) begin
          if (acc_done) begin
            data_out_tdata  <= avg_w;
            data_out_tvalid <= 1'b1;
            data_out_tlast  <= data_in_tlast && (rem_n == CW'(1));
            rem             <= rem_n;
            last_seen       <= data_in_tlast;
            cnt             <= '0;
            state           <= ST_OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_OUT: if (data_out_tready) begin
          if (rem == CW'(1)) begin
            data_out_tvalid <= 1'b0;
            data_out_tlast  <= 1'b0;
            state           <= last_seen ? ST_IDLE : ST_ACC;
          end else begin
            rem            <= rem - CW'(1);
            data_out_tlast <= last_seen && (rem == CW'(2));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wn_pdcchrx_freq_toneavg_nrx.sv
// Directed lockstep bench for the tone averager; expectations hand-computed per vector.
module tb_wn_pdcchrx_freq_toneavg_nrx;
  localparam int NRX = 2, DW = 16, W = NRX*2*DW;
`ifdef WN_TONEAVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic         clk = 1'b0, rstn = 1'b0;
  logic [4:0]   config_in_tdata = '0;
  logic         config_in_tvalid = 1'b0, config_in_tready;
  logic [W-1:0] data_in_tdata = '0, data_out_tdata;
  logic         data_in_tvalid = 1'b0, data_in_tready, data_in_tlast = 1'b0;
  logic         data_out_tvalid, data_out_tready = 1'b1, data_out_tlast;

  wn_pdcchrx_freq_toneavg_nrx #(.nRx(NRX), .DW(DW), .MAX_LOG2N(4)) dut (
    .clk(clk), .rstn(rstn),
    .config_in_tdata(config_in_tdata), .config_in_tvalid(config_in_tvalid), .config_in_tready(config_in_tready),
    .data_in_tdata(data_in_tdata), .data_in_tvalid(data_in_tvalid), .data_in_tready(data_in_tready),
    .data_in_tlast(data_in_tlast),
    .data_out_tdata(data_out_tdata), .data_out_tvalid(data_out_tvalid), .data_out_tready(data_out_tready),
    .data_out_tlast(data_out_tlast)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int i0, input int q0, input int i1, input int q1);
    return {16'(q1), 16'(i1), 16'(q0), 16'(i0)};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic l);
    @(negedge clk);
    data_in_tvalid = v; data_in_tdata = d; data_in_tlast = l;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [2:0] l2);
    @(negedge clk);
    chk("cfg_rdy", config_in_tready, 1);
    config_in_tvalid = 1'b1; config_in_tdata = {m, l2};
    tick;
    @(negedge clk);
    config_in_tvalid = 1'b0;
  endtask

  task automatic out_beat(input string tag, input logic [W-1:0] d, input logic l);
    chk({tag, "_vld"}, data_out_tvalid, 1);
    chk({tag, "_dat"}, data_out_tdata, d);
    chk({tag, "_lst"}, data_out_tlast, l);
  endtask

  task automatic end_frame(input string tag);
    drive(1'b0, '0, 1'b0);
    tick;
    chk({tag, "_drain"}, data_out_tvalid, 0);
    chk({tag, "_idle"}, config_in_tready, 1);
  endtask

  logic [W-1:0] v;

  initial begin
    // reset state
    repeat (3) tick;
    chk("rst_vld", data_out_tvalid, 0);
    chk("rst_dat", data_out_tdata, 0);
    chk("rst_lst", data_out_tlast, 0);
    chk("rst_crdy", config_in_tready, 0);
    chk("rst_drdy", data_in_tready, 0);
    @(negedge clk); rstn = 1'b1;
    tick;
    chk("idle_crdy", config_in_tready, 1);
    chk("idle_drdy", data_in_tready, 0);

    // bypass, 8 beats, 1-cycle latency
    cfg(2'b00, 3'd0);
    for (int k = 0; k < 8; k++) begin
      v = pk(k*3+1, -k, 100+k, 7);
      drive(1'b1, v, k == 7);
      tick;
      out_beat("byp", v, k == 7);
    end
    end_frame("byp");

    // bypass (mode 11) with backpressure: output must hold
    cfg(2'b11, 3'd0);
    drive(1'b1, pk(11, 22, 33, 44), 1'b0);
    tick;
    out_beat("bp_a", pk(11, 22, 33, 44), 0);
    drive(1'b1, pk(-1, -2, -3, -4), 1'b1);
    data_out_tready = 1'b0;
    #1 chk("bp_in_rdy0", data_in_tready, 0);
    tick;
    out_beat("bp_hold", pk(11, 22, 33, 44), 0);
    @(negedge clk); data_out_tready = 1'b1;
    #1 chk("bp_in_rdy1", data_in_tready, 1);
    tick;
    out_beat("bp_b", pk(-1, -2, -3, -4), 1);
    end_frame("bp");

    // decimate N=4: I 1..4 sum 10, Q -10, rx1 I sum 401
    cfg(2'b01, 3'd2);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, pk(k+1, -(k+1), (k == 3) ? 101 : 100, 0), k == 3);
      tick;
      if (k < 3) chk("dec_early", data_out_tvalid, 0);
    end
    out_beat("dec", pk(RND ? 3 : 2, RND ? -2 : -3, 100, 0), 1);
    drive(1'b0, '0, 1'b0);
    #1 chk("dec_out_drdy", data_in_tready, 0);
    tick;
    chk("dec_drain", data_out_tvalid, 0);

    // replicate N=2 at full scale: no wrap
    cfg(2'b10, 3'd1);
    drive(1'b1, pk(32767, -32768, 5, 0), 1'b0); tick;
    drive(1'b1, pk(32767, -32768, 6, 0), 1'b1); tick;
    out_beat("rep1", pk(32767, -32768, RND ? 6 : 5, 0), 0);
    drive(1'b0, '0, 1'b0);
    #1 chk("rep_out_drdy", data_in_tready, 0);
    tick;
    out_beat("rep2", pk(32767, -32768, RND ? 6 : 5, 0), 1);
    end_frame("rep");

    // decimate N=8 cut short by tlast after 3 beats: zero-padded average
    cfg(2'b01, 3'd3);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, pk(8, -8, 0, 0), k == 2); tick;
    end
    out_beat("part", pk(3, -3, 0, 0), 1);
    end_frame("part");

    // replicate N=4 partial (3 beats) -> 3 copies, with a stall
    cfg(2'b10, 3'd2);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, pk(4, 4, 4, 4), k == 2); tick;
    end
    out_beat("rpart1", pk(3, 3, 3, 3), 0);
    drive(1'b0, '0, 1'b0);
    data_out_tready = 1'b0;
    tick;
    out_beat("rpart_hold", pk(3, 3, 3, 3), 0);
    @(negedge clk); data_out_tready = 1'b1;
    tick;
    out_beat("rpart2", pk(3, 3, 3, 3), 0);
    tick;
    out_beat("rpart3", pk(3, 3, 3, 3), 1);
    tick;
    chk("rpart_drain", data_out_tvalid, 0);

    // log2N=0 decimate: identity, one beat per input
    cfg(2'b01, 3'd0);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: v = pk(-5, 7, 1234, -1234);
        1: v = pk(1, 2, 3, 4);
        default: v = pk(32767, -32768, 0, 0);
      endcase
      drive(1'b1, v, k == 2); tick;
      out_beat("l2n0", v, k == 2);
      drive(1'b0, '0, 1'b0); tick;
      chk("l2n0_gap", data_out_tvalid, 0);
    end

    // log2N=7 clamps to 4: group of 16, I=0..15 sum 120
    cfg(2'b01, 3'd7);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, pk(k, 0, 0, 0), k == 15); tick;
      if (k == 7 || k == 14) chk("clamp_early", data_out_tvalid, 0);
    end
    out_beat("clamp", pk(RND ? 8 : 7, 0, 0, 0), 1);
    end_frame("clamp");

    // reset mid-accumulation, then a clean frame with no residue
    cfg(2'b01, 3'd2);
    drive(1'b1, pk(100, 100, 100, 100), 1'b0); tick;
    drive(1'b1, pk(100, 100, 100, 100), 1'b0); tick;
    @(negedge clk); rstn = 1'b0; data_in_tvalid = 1'b0;
    tick;
    chk("mrst_vld", data_out_tvalid, 0);
    chk("mrst_dat", data_out_tdata, 0);
    chk("mrst_lst", data_out_tlast, 0);
    chk("mrst_crdy", config_in_tready, 0);
    chk("mrst_drdy", data_in_tready, 0);
    @(negedge clk); rstn = 1'b1;
    cfg(2'b01, 3'd1);
    drive(1'b1, pk(2, 2, 2, 2), 1'b0); tick;
    drive(1'b1, pk(4, 4, 4, 4), 1'b1); tick;
    out_beat("post_rst", pk(3, 3, 3, 3), 1);
    end_frame("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/wn_pdcchrx_freq_toneavg_nrx.md
WN_PDCCHRX_FREQ_TONEAVG_NRX -- requirements
Module: wn_pdcchrx_freq_toneavg_nrx

Interface
REQ-001 SHALL have parameter nRx, default 2, number of receive antennas (1..8).
REQ-002 SHALL have parameter DW, default 16, signed width of each I and Q component.
REQ-003 SHALL have parameter MAX_LOG2N, default 4, maximum log2 of the averaging group length.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have ports config_in_tdata  input  5, config_in_tvalid  input  1, config_in_tready  output  1; [2:0] = log2N, [4:3] = mode.
REQ-007 SHALL have ports data_in_tdata  input  nRx*2*DW, data_in_tvalid  input  1, data_in_tready  output  1, data_in_tlast  input  1; per rx r: I at [2*DW*r +: DW], Q above it.
REQ-008 SHALL have ports data_out_tdata  output  nRx*2*DW, data_out_tvalid  output  1, data_out_tready  input  1, data_out_tlast  output  1; same packing as input.

Function
REQ-009 SHALL use AXI-Stream handshakes: transfer on tvalid&&tready; output tdata/tlast stable while tvalid high and tready low.
REQ-010 SHALL run FSM IDLE -> (config accepted) PASS / ACC; ACC -> OUT on group complete or tlast; OUT -> ACC after group emitted; OUT/PASS -> IDLE after the output beat carrying tlast.
REQ-011 SHALL assert config_in_tready only in IDLE; data_in_tready SHALL be 0 in IDLE and OUT.
REQ-012 SHALL clamp log2N > MAX_LOG2N to MAX_LOG2N; N = 2^log2N.
REQ-013 SHALL treat mode 00 as bypass, 01 as decimate (one output per group), 10 as replicate (N identical outputs per group), 11 as bypass.
REQ-014 In bypass, SHALL register input to output with 1-cycle latency and full throughput (data_in_tready = data_out_tready || !data_out_tvalid).
REQ-015 In ACC, SHALL sum I and Q independently per rx into DW+MAX_LOG2N-bit signed accumulators, one sample per accepted beat.
REQ-016 SHALL compute average = sum arithmetically shifted right by log2N, then saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-017 A partial group terminated by tlast SHALL still be shifted by log2N (zero-padding semantics); replicate mode SHALL then emit only the received count of copies.
REQ-018 First averaged output SHALL be valid 1 cycle after the group's last input beat.
REQ-019 data_out_tlast SHALL be set only on the final output beat of the group containing input tlast (the input beat itself in bypass).
REQ-020 log2N = 0 in decimate/replicate SHALL produce output equal to input, one beat per input.
REQ-021 Accumulators and group counter SHALL clear at start of each group; config SHALL be held until IDLE re-entry.

Reset
REQ-022 On rstn low at a clock edge, SHALL enter IDLE, clear accumulators, counters, config register; all tvalid, tready, tlast outputs 0; data_out_tdata 0.
REQ-023 Reset mid-frame SHALL discard partial groups; first beat after release SHALL require new config.

Configuration
REQ-024 With WN_TONEAVG_ROUND_EN defined, SHALL add 2^(log2N-1) (0 when log2N=0) before the shift (round half up); without it, SHALL truncate (floor).

Structure
REQ-025 Package wn_pdcchrx_toneavg_pkg SHALL hold mode enum, FSM state enum, config field positions and width constants.
REQ-026 Sub-module wn_pdcchrx_toneavg_acc (one signed component: accumulate, round, shift, saturate) SHALL be instantiated 2*nRx times.

Verification
REQ-027 Bypass, 8 beats, tlast on 8th, tready=1 -> 8 identical beats, 1-cycle latency, tlast on 8th only.
REQ-028 Decimate log2N=2, I inputs 1,2,3,4 (rx0) -> single output I=2 without ROUND_EN, I=3 with ROUND_EN (sum 10).
REQ-029 Replicate log2N=1, inputs 0x7FFF,0x7FFF then tlast -> two beats 0x7FFF, second with tlast; 0x8000,0x8000 -> 0x8000 (no overflow).
REQ-030 Decimate log2N=3, tlast after 3 beats of I=8 -> one output I=3 (24>>3), tlast set.
REQ-031 Random tvalid/tready throttling (up to 10-cycle gaps) across all modes -> outputs match golden CSV within ±1 LSB, no lost/duplicated beats.
REQ-032 Reset asserted mid-ACC -> all outputs 0 next cycle; following config+frame processed correctly with no residue.
